// File: rtl/conv2d_pkg.sv
// conv2d_pkg: shared conv2d pipeline constants: control word layout, Q8.8 pixel format, stage FSM encoding.
package conv2d_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS = 8;
  localparam int ADDR_WIDTH = 28;
  localparam int CTRL0_START = 0;
  localparam int CTRL0_DONE = 1;
  localparam int CTRL0_CONV = 2;
  localparam int CTRL0_BNRELU = 3;
  localparam int CTRL0_MAXPOOL = 4;
  localparam int CTRL0_CUR_LAYER_LSB = 8;
  localparam int CTRL0_CUR_LAYER_W = 8;
  localparam int CTRL1_WIDTH_LSB = 0;
  localparam int CTRL1_HEIGHT_LSB = 8;
  localparam int CTRL1_KERNEL_LSB = 16;
  localparam int CTRL1_PADDING_LSB = 20;
  localparam int CTRL1_STRIDE_LSB = 22;
  localparam int CTRL2_IN_CH_LSB = 0;
  localparam int CTRL2_OUT_CH_LSB = 16;
  localparam int CTRL2_CH_W = 10;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;
endpackage

// File: rtl/pool_row_buffer.sv
// pool_row_buffer: line store of horizontal pair maxima from the even row, read back on the odd row.
module pool_row_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 128,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: 2x2/stride-2 signed max-pool over a raster, channel-major pixel stream,
// writing pooled pixels through the conv-style addr/we/data port.
module maxpool2x2_stream #(
  parameter int DATA_WIDTH = conv2d_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = conv2d_pkg::ADDR_WIDTH,
  parameter int MAX_WIDTH = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_width,
  input  logic [7:0]            i_height,
  input  logic [9:0]            i_channels,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic                  i_valid,
  input  logic [31:0]           i_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_outimg_addr,
  output logic                  o_outimg_we,
  output logic [31:0]           o_outimg_data
);
  import conv2d_pkg::*;
  localparam int BW = $clog2(MAX_WIDTH / 2);
  state_t r_state, w_next;
  logic [7:0] r_w, r_h, r_col, r_row;
  logic [9:0] r_c, r_ch;
  logic [6:0] r_wp, r_hp;
  logic [13:0] r_plane;
  logic [ADDR_WIDTH-1:0] r_base, r_ch_off, r_row_off, r_addr;
  logic [DATA_WIDTH-1:0] r_hold, r_pooled, w_px, w_pair, w_quad, w_rd;
  logic r_we, r_done;
  logic w_run_px, w_col_last, w_row_last, w_ch_last, w_last, w_in_win, w_buf_we, w_fire, w_degen;
  logic w_unused_data;
  assign w_unused_data = |i_data[31:DATA_WIDTH];
  assign w_px = i_data[DATA_WIDTH-1:0];
  assign w_run_px = (r_state == S_RUN) && i_valid;
  assign w_col_last = r_col == r_w - 8'd1;
  assign w_row_last = r_row == r_h - 8'd1;
  assign w_ch_last = r_ch == r_c - 10'd1;
  assign w_last = w_run_px && w_col_last && w_row_last && w_ch_last;
  assign w_in_win = (r_col < {r_wp, 1'b0}) && (r_row < {r_hp, 1'b0});
  assign w_buf_we = w_run_px && w_in_win && r_col[0] && !r_row[0];
  assign w_fire = w_run_px && w_in_win && r_col[0] && r_row[0];
  assign w_degen = (i_width < 8'd2) || (i_height < 8'd2) || (i_channels == 10'd0);
  assign w_pair = $signed(r_hold) > $signed(w_px) ? r_hold : w_px;
  assign w_quad = $signed(w_pair) > $signed(w_rd) ? w_pair : w_rd;
  pool_row_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_WIDTH / 2)) u_rowbuf (
    .i_clk  (i_clk),
    .i_we   (w_buf_we),
    .i_addr (r_col[BW:1]),
    .i_wdata(w_pair),
    .o_rdata(w_rd)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = w_degen ? S_FIN : S_RUN;
      S_RUN: if (w_last) w_next = S_FIN;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // Address offsets advance incrementally: +Wp per completed pooled row, +Wp*Hp per channel.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      {r_w, r_h, r_c, r_wp, r_hp, r_plane, r_base} <= '0;
      {r_col, r_row, r_ch, r_ch_off, r_row_off} <= '0;
      {r_hold, r_pooled, r_addr, r_we, r_done} <= '0;
    end else begin
      r_we <= w_fire;
      if (r_state == S_IDLE && i_start) begin
        r_w <= i_width;
        r_h <= i_height;
        r_c <= i_channels;
        r_base <= i_base_addr;
        r_wp <= i_width[7:1];
        r_hp <= i_height[7:1];
        r_plane <= {7'd0, i_width[7:1]} * {7'd0, i_height[7:1]};
        {r_col, r_row, r_ch, r_ch_off, r_row_off, r_done} <= '0;
      end
      if (r_state == S_FIN) r_done <= 1'b1;
      if (w_fire) begin
        r_addr <= r_base + r_ch_off + r_row_off + ADDR_WIDTH'(r_col[BW:1]);
        r_pooled <= w_quad;
      end
      if (w_run_px) begin
        if (!r_col[0]) r_hold <= w_px;
        r_col <= w_col_last ? 8'd0 : r_col + 8'd1;
        if (w_col_last) begin
          r_row <= w_row_last ? 8'd0 : r_row + 8'd1;
          r_row_off <= w_row_last ? '0 : r_row[0] ? r_row_off + ADDR_WIDTH'(r_wp) : r_row_off;
          if (w_row_last) begin
            r_ch <= r_ch + 10'd1;
            r_ch_off <= r_ch_off + ADDR_WIDTH'(r_plane);
          end
        end
      end
    end
  end
  assign o_busy = r_state != S_IDLE;
  assign o_done = r_done;
  assign o_outimg_we = r_we;
  assign o_outimg_addr = r_addr;
  assign o_outimg_data = {{(32 - DATA_WIDTH){1'b0}}, r_pooled};
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream: scoreboard bench; expected writes are queued at stimulus time and
// matched in order against every o_outimg_we strobe.
module tb_maxpool2x2_stream;
  logic i_clk = 0, i_rst = 0, i_start = 0, i_valid = 0;
  logic [7:0] i_width = 0, i_height = 0;
  logic [9:0] i_channels = 0;
  logic [27:0] i_base_addr = 0;
  logic [31:0] i_data = 0;
  logic o_busy, o_done, o_outimg_we;
  logic [27:0] o_outimg_addr;
  logic [31:0] o_outimg_data;
  int n_vec = 0, n_err = 0, n_wr = 0;
  logic [59:0] sb[$];
  logic [15:0] img[];

  always #5 i_clk = ~i_clk;

  maxpool2x2_stream dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_width(i_width), .i_height(i_height),
    .i_channels(i_channels), .i_base_addr(i_base_addr), .i_valid(i_valid), .i_data(i_data),
    .o_busy(o_busy), .o_done(o_done), .o_outimg_addr(o_outimg_addr), .o_outimg_we(o_outimg_we),
    .o_outimg_data(o_outimg_data)
  );

  always @(negedge i_clk) begin
    if (i_rst && o_outimg_we) begin
      logic [59:0] e;
      n_wr++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected addr=%h data=%h want no write", o_outimg_addr, o_outimg_data);
      end else begin
        e = sb.pop_front();
        if ({o_outimg_addr, o_outimg_data} !== e) begin
          n_err++;
          $display("FAIL wr_match got addr=%h data=%h want addr=%h data=%h",
                   o_outimg_addr, o_outimg_data, e[59:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic expect_pool(input int w, input int h, input int c, input logic [27:0] base);
    int wp = w / 2, hp = h / 2;
    logic signed [15:0] m, v;
    for (int ci = 0; ci < c; ci++)
      for (int y = 0; y < hp; y++)
        for (int x = 0; x < wp; x++) begin
          m = img[(ci * h + 2 * y) * w + 2 * x];
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = img[(ci * h + 2 * y + dy) * w + 2 * x + dx];
              if (v > m) m = v;
            end
          sb.push_back({28'(base + 28'(ci * wp * hp + y * wp + x)), 16'h0000, m});
        end
  endtask

  task automatic pulse_start(input int w, input int h, input int c, input logic [27:0] base);
    @(posedge i_clk); #1;
    i_width = 8'(w); i_height = 8'(h); i_channels = 10'(c); i_base_addr = base; i_start = 1;
    @(posedge i_clk); #1;
    i_start = 0;
  endtask

  task automatic send_pixels(input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      i_valid = 1;
      i_data = {16'hA5A5, img[k]};
      @(posedge i_clk); #1;
      i_valid = 0;
      if (gaps) begin
        @(posedge i_clk); #1;
      end
    end
  endtask

  task automatic wait_done();
    for (int t = 0; t < 50 && o_done !== 1'b1; t++) @(negedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({o_busy, o_done, o_outimg_we} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got=%b want=000", {o_busy, o_done, o_outimg_we});
    end
    n_vec++;
    if ({o_outimg_addr, o_outimg_data} !== 60'd0) begin
      n_err++; $display("FAIL reset_bus got addr=%h data=%h want 0", o_outimg_addr, o_outimg_data);
    end
    @(negedge i_clk); i_rst = 1;
  endtask

  task automatic test_basic_4x4();
    int wr0 = n_wr;
    img = new[16];
    for (int k = 0; k < 16; k++) img[k] = 16'(k * 256);
    pulse_start(4, 4, 1, 28'h0);
    sb.push_back({28'd0, 32'h0500}); sb.push_back({28'd1, 32'h0700});
    sb.push_back({28'd2, 32'h0D00}); sb.push_back({28'd3, 32'h0F00});
    send_pixels(16, 0);
    wait_done();
    n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL basic_done got=%b want=1", o_done); end
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy got=%b want=0", o_busy); end
    n_vec++; if (n_wr - wr0 !== 4) begin n_err++; $display("FAIL basic_count got=%0d want=4", n_wr - wr0); end
    n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL basic_pending got=%0d want=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_signed();
    int wr0 = n_wr;
    img = new[4];
    img[0] = 16'hFF00; img[1] = 16'hFE00; img[2] = 16'h8000; img[3] = 16'hFF80;
    pulse_start(2, 2, 1, 28'h0);
    sb.push_back({28'd0, 32'h0000FF80});
    send_pixels(4, 0);
    wait_done();
    n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL signed_done got=%b want=1", o_done); end
    n_vec++; if (n_wr - wr0 !== 1) begin n_err++; $display("FAIL signed_count got=%0d want=1", n_wr - wr0); end
    n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL signed_pending got=%0d want=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_odd_dims();
    int wr0 = n_wr;
    img = new[15];
    for (int k = 0; k < 15; k++) img[k] = (k % 5 == 4) ? 16'h7F00 : 16'h0100;
    pulse_start(5, 3, 1, 28'h0);
    sb.push_back({28'd0, 32'h0100}); sb.push_back({28'd1, 32'h0100});
    send_pixels(15, 0);
    wait_done();
    n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL odd_done got=%b want=1", o_done); end
    n_vec++; if (n_wr - wr0 !== 2) begin n_err++; $display("FAIL odd_count got=%0d want=2", n_wr - wr0); end
    n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL odd_pending got=%0d want=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_multi_channel_gaps();
    int wr0 = n_wr;
    img = new[32];
    for (int k = 0; k < 32; k++) img[k] = 16'($urandom);
    expect_pool(4, 4, 2, 28'h100);
    pulse_start(4, 4, 2, 28'h100);
    n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL mc_done_clear got=%b want=0", o_done); end
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL mc_busy got=%b want=1", o_busy); end
    send_pixels(32, 1);
    wait_done();
    n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL mc_done got=%b want=1", o_done); end
    n_vec++; if (n_wr - wr0 !== 8) begin n_err++; $display("FAIL mc_count got=%0d want=8", n_wr - wr0); end
    n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL mc_pending got=%0d want=0", sb.size()); end
    sb.delete();
  endtask

  task automatic test_degenerate();
    for (int v = 0; v < 2; v++) begin
      int wr0 = n_wr;
      pulse_start(v == 0 ? 1 : 4, 4, v == 0 ? 1 : 0, 28'h0);
      @(posedge i_clk); #1;
      n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL degen%0d_done got=%b want=1", v, o_done); end
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL degen%0d_busy got=%b want=0", v, o_busy); end
      @(negedge i_clk);
      n_vec++; if (n_wr - wr0 !== 0) begin n_err++; $display("FAIL degen%0d_count got=%0d want=0", v, n_wr - wr0); end
    end
  endtask

  task automatic test_reset_mid_run();
    int wr0;
    img = new[16];
    for (int k = 0; k < 16; k++) img[k] = 16'(k * 256);
    pulse_start(4, 4, 1, 28'h0);
    send_pixels(6, 0);
    n_vec++; if (o_outimg_we !== 1'b1) begin n_err++; $display("FAIL mid_pre_we got=%b want=1", o_outimg_we); end
    n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL mid_pre_busy got=%b want=1", o_busy); end
    i_rst = 0;
    #1;
    n_vec++;
    if ({o_busy, o_done, o_outimg_we} !== 3'b000) begin
      n_err++; $display("FAIL mid_rst_flags got=%b want=000", {o_busy, o_done, o_outimg_we});
    end
    n_vec++;
    if ({o_outimg_addr, o_outimg_data} !== 60'd0) begin
      n_err++; $display("FAIL mid_rst_bus got addr=%h data=%h want 0", o_outimg_addr, o_outimg_data);
    end
    sb.delete();
    @(negedge i_clk); i_rst = 1;
    wr0 = n_wr;
    pulse_start(4, 4, 1, 28'h0);
    sb.push_back({28'd0, 32'h0500}); sb.push_back({28'd1, 32'h0700});
    sb.push_back({28'd2, 32'h0D00}); sb.push_back({28'd3, 32'h0F00});
    send_pixels(16, 0);
    wait_done();
    n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL mid_rerun_done got=%b want=1", o_done); end
    n_vec++; if (n_wr - wr0 !== 4) begin n_err++; $display("FAIL mid_rerun_count got=%0d want=4", n_wr - wr0); end
    n_vec++; if (sb.size() !== 0) begin n_err++; $display("FAIL mid_rerun_pending got=%0d want=0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_basic_4x4();
    test_signed();
    test_odd_dims();
    test_multi_channel_gaps();
    test_degenerate();
    test_reset_mid_run();
    repeat (3) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/maxpool2x2_stream.md
Name: maxpool2x2_stream

Overview:
- Downstream stage of top_conv2d. Runs when the layer control word has maxpool=1 (bit 4 of ctrl word 0).
- Consumes the conv/BN-ReLU output pixel stream: Q8.8 signed, raster order, channel-major.
- Performs 2x2 max-pooling with stride 2 and writes pooled pixels to output image memory through the same addr/we/data write-port format the conv stage uses.

Parameters:
- DATA_WIDTH, 16, pixel width (signed Q8.8).
- ADDR_WIDTH, 28, output image memory address width.
- MAX_WIDTH, 256, largest supported input row width; the row buffer depth is MAX_WIDTH/2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse; latches config and begins a layer.
- i_width  in  8  input feature-map width (conv output width).
- i_height  in  8  input feature-map height.
- i_channels  in  10  number of channels in the stream.
- i_base_addr  in  ADDR_WIDTH  output write base address.
- i_valid  in  1  input pixel strobe (conv o_outimg_we).
- i_data  in  32  input pixel; only [DATA_WIDTH-1:0] is used, as signed.
- o_busy  out  1  high from start until the last output is written.
- o_done  out  1  sticky completion flag, cleared by the next i_start.
- o_outimg_addr  out  ADDR_WIDTH  output write address.
- o_outimg_we  out  1  output write enable, one-cycle strobe per pooled pixel.
- o_outimg_data  out  32  {16'b0, pooled pixel}.

Behaviour:
- Reset (i_rst=0, asynchronous): state IDLE.
  - o_busy=0, o_done=0, o_outimg_we=0, o_outimg_addr=0, o_outimg_data=0.
  - All counters are 0. Row buffer contents are don't-care.
- FSM states: IDLE, RUN, FIN.
  - IDLE: on i_start, latch all config, clear col/row/ch counters and o_done, go to RUN.
  - Degenerate start: if i_width<2, i_height<2 or i_channels=0, go to FIN instead with no writes.
  - RUN: count pixels only on i_valid. col wraps at W-1, then row increments. row wraps at H-1, then ch increments. After the last pixel of channel C-1, go to FIN.
  - FIN: o_done=1 and o_busy=0 on the next cycle, then return to IDLE. o_done stays high until the next i_start.
- i_valid in IDLE or FIN is ignored. i_start while in RUN is ignored. i_valid may have arbitrary gaps; there is no backpressure.
- Pooling dimensions: Wp=floor(W/2), Hp=floor(H/2). For odd W the last column is discarded; for odd H the last row is discarded.
- Pooling datapath, for pixels with col < 2*Wp and row < 2*Hp:
  - Even col: hold <= px.
  - Odd col, even row: rowbuf[col>>1] <= smax(hold, px).
  - Odd col, odd row: result = smax(smax(hold, px), rowbuf[col>>1]); this issues a write.
- Comparisons are signed DATA_WIDTH-bit. Ties take either operand (the values are equal).
- Write timing: registered. o_outimg_we pulses for one cycle on the cycle after the completing i_valid.
  - o_outimg_addr = base + ch*Wp*Hp + (row>>1)*Wp + (col>>1).
  - Address arithmetic is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH.
- Back-to-back valid input gives at most one write every 2 cycles.
- The transition to FIN happens after the final write has been issued.
- Mid-operation reset: immediate return to IDLE with all outputs at reset values. No partial writes.

Decomposition:
- Shared package (conv2d_pkg): ctrl word field positions (start, done, conv, bnrelu, maxpool, cur_layer, width/height/kernel/padding/stride, in/out-channel), Q8.8 DATA_WIDTH, ADDR_WIDTH, and the FSM state encoding.
- One sub-module: pool_row_buffer.
  - Single-port, MAX_WIDTH/2 x DATA_WIDTH.
  - Synchronous write, combinational read at the addressed entry.

Test Plan:
- 4x4, 1 channel, base 0, pixels k*0x0100 for k=0..15 with continuous valid -> 4 writes:
  - addr 0 data 0x0500, addr 1 data 0x0700, addr 2 data 0x0D00, addr 3 data 0x0F00.
  - o_done=1 afterwards.
- Signed compare: 2x2 map {0xFF00, 0xFE00, 0x8000, 0xFF80} -> single write of 0x0000FF80.
- Odd dims: W=5, H=3, all pixels 0x0100 except col 4 = 0x7F00 -> exactly 2 writes (addr 0, 1), both 0x0100. The discarded column and row never appear in the output.
- Multi-channel with gaps: 2 channels of 4x4, base 0x100, valid toggling 1-0-1 -> 8 writes at 0x100..0x107, channel-1 results at 0x104..0x107.
- Degenerate start: W=1 -> no o_outimg_we, o_done=1 within 2 cycles.
- Reset mid-run: assert i_rst=0 after 6 pixels of a 4x4 frame -> outputs drop to 0 immediately. A subsequent full 4x4 run gives the same results as the first test.
